// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: the value/mode fed to the scan driver and the multiplexed
// seven-segment pins it drives back out.
interface seg7_scan_driver_if;
  logic [31:0] data_in;
  logic        dec_mode;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output data_in,
    output dec_mode,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  data_in,
    input  dec_mode,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver: tear-free frame capture, hex or
// sequential double-dabble decimal, leading-zero blanking and decimal overflow dashes.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic          clk,
  input logic          rst,
  seg7_scan_driver_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [31:0]      r_snap;
  logic             r_snap_dec;
  logic [39:0]      r_bcd;
  logic [4:0]       r_cnt;
  logic [31:0]      r_nib;
  logic             r_ovf;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             w_tick;
  logic             w_boundary;
  logic [7:0]       w_blank;
  logic [3:0]       w_cur_nib;

  // One double-dabble iteration: correct every BCD digit, then shift in the next binary bit.
  function automatic logic [39:0] dd_step(input logic [39:0] bcd, input logic bit_in);
    logic [39:0] adj;
    adj = 40'd0;
    for (int i = 0; i < 10; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
    end
    return {adj[38:0], bit_in};
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_div == DIV_MAX);
  assign w_boundary = w_tick && (r_idx == 3'd7);
  assign w_cur_nib  = r_nib[{r_idx, 2'b00} +: 4];

  // Slot timer and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
      r_idx <= r_idx;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Boundaries arriving while a conversion is still running are simply ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_boundary) begin
          w_state_nxt = bus.dec_mode ? S_CONV : S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      S_LOAD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot capture, conversion datapath and display-nibble load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= 32'd0;
      r_snap_dec <= 1'b0;
      r_bcd      <= 40'd0;
      r_cnt      <= 5'd0;
      r_nib      <= 32'd0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_boundary) begin
            r_snap     <= bus.data_in;
            r_snap_dec <= bus.dec_mode;
            r_bcd      <= 40'd0;
            r_cnt      <= 5'd0;
          end
        end
        S_CONV: begin
          r_bcd  <= dd_step(r_bcd, r_snap[31]);
          r_snap <= {r_snap[30:0], 1'b0};
          r_cnt  <= r_cnt + 5'd1;
        end
        S_LOAD: begin
          if (r_snap_dec) begin
            r_nib <= r_bcd[31:0];
            r_ovf <= |r_bcd[39:32];
          end else begin
            r_nib <= r_snap;
            r_ovf <= 1'b0;
          end
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  // Digit k blanks when it and every more-significant nibble are zero; dashes disable blanking.
  always_comb begin
    w_blank = 8'h00;
    for (int k = 1; k < 8; k++) begin
      w_blank[k] = BLANK_LZ && !r_ovf && ((r_nib >> (4 * k)) == 32'd0);
    end
  end

  // Registered pin drivers, one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_blank[r_idx]) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= r_ovf ? 7'b0111111 : hex7(w_cur_nib);
      r_dp  <= 1'b1;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
